// File: rtl/semafor_pkg.sv
// Shared constants for the traffic-light timebase: timer state encodings,
// default timebase sizing and the phase durations used by the light FSM.
package semafor_pkg;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    typedef enum logic {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN
    } tmr_state_t;

    localparam int CK_DIV_DEF = 4;
    localparam int TIME_W_DEF = 6;

    // Phase durations in ticks
    localparam int T_RED    = 10;
    localparam int T_YELLOW = 3;
    localparam int T_GREEN  = 8;

endpackage

// File: rtl/ck_prescaler.sv
// Prescaler: divides clk into a registered one-cycle tick every CK_DIV enabled cycles.
// clr phase-aligns the count (used on timer load); tick still reflects the current wrap.
module ck_prescaler
    import semafor_pkg::*;
#(
    parameter int CK_DIV = CK_DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic wrap,
    output logic tick
);

    localparam int PW = (CK_DIV > 2) ? $clog2(CK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(CK_DIV - 1);

    logic [PW-1:0] pre_cnt;

    assign wrap = en && (pre_cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            tick <= wrap;
            if (clr || wrap)
                pre_cnt <= '0;
            else if (en)
                pre_cnt <= pre_cnt + PW'(1);
        end
    end

endmodule

// File: rtl/ck_tick_timer.sv
// Tick timebase for the semafor controller: prescaler plus loadable down-counter
// with busy/done. Optional CK_TIMER_AUTORELOAD_EN adds auto_rld periodic reload.
module ck_tick_timer
    import semafor_pkg::*;
#(
    parameter int CK_DIV = CK_DIV_DEF,
    parameter int TIME_W = TIME_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load,
    input  logic [TIME_W-1:0] load_val,
`ifdef CK_TIMER_AUTORELOAD_EN
    input  logic              auto_rld,
`endif
    output logic              tick,
    output logic              busy,
    output logic              done,
    output logic [TIME_W-1:0] remaining
);

    tmr_state_t state;
    logic       wrap;
    logic       clr;

`ifdef CK_TIMER_AUTORELOAD_EN
    logic [TIME_W-1:0] rld_val;
`endif

    // Restart the tick phase on any load that leaves the timer running or
    // cancels a running phase; a zero load in IDLE leaves the prescaler alone.
    assign clr = load && ((state == S_RUN) || (load_val != '0));

    ck_prescaler #(.CK_DIV(CK_DIV)) u_pre (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (clr),
        .wrap (wrap),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            remaining <= '0;
`ifdef CK_TIMER_AUTORELOAD_EN
            rld_val   <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (load) begin
                if (load_val != '0) begin
                    state     <= S_RUN;
                    busy      <= 1'b1;
                    remaining <= load_val;
`ifdef CK_TIMER_AUTORELOAD_EN
                    rld_val   <= load_val;
`endif
                end else begin
                    state     <= S_IDLE;
                    busy      <= 1'b0;
                    remaining <= '0;
                    done      <= 1'b1;
                end
            end else if (state == S_RUN && wrap) begin
                if (remaining > TIME_W'(1)) begin
                    remaining <= remaining - TIME_W'(1);
                end else begin
                    done <= 1'b1;
`ifdef CK_TIMER_AUTORELOAD_EN
                    if (auto_rld) begin
                        remaining <= rld_val;
                    end else begin
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                        remaining <= '0;
                    end
`else
                    state     <= S_IDLE;
                    busy      <= 1'b0;
                    remaining <= '0;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_ck_tick_timer.sv
// Directed bench for ck_tick_timer at CK_DIV=4, TIME_W=4 with hand-computed expectations.
module tb_ck_tick_timer;

    localparam int CK_DIV = 4;
    localparam int TIME_W = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b0;
    logic              load = 1'b0;
    logic [TIME_W-1:0] load_val = '0;
    logic              tick;
    logic              busy;
    logic              done;
    logic [TIME_W-1:0] remaining;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ck_tick_timer #(.CK_DIV(CK_DIV), .TIME_W(TIME_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .load      (load),
        .load_val  (load_val),
`ifdef CK_TIMER_AUTORELOAD_EN
        .auto_rld  (1'b0),
`endif
        .tick      (tick),
        .busy      (busy),
        .done      (done),
        .remaining (remaining)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n edges; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // Reset held for two edges
        step(2);
        chk("rst_tick", tick, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rem", remaining, 0);

        rst = 1'b0;
        en  = 1'b1;
        step(3);
        chk("pre_tick3", tick, 0);
        step(1);
        chk("pre_tick4", tick, 1);
        step(1);
        chk("pre_tick5", tick, 0);
        step(3);
        chk("pre_tick8", tick, 1);

        // Basic run, load 3
        load = 1'b1; load_val = 4'd3;
        step(1);
        load = 1'b0;
        chk("run_busy0", busy, 1);
        chk("run_rem0", remaining, 3);
        step(3);
        chk("run_rem3", remaining, 3);
        step(1);
        chk("run_rem4", remaining, 2);
        chk("run_tick4", tick, 1);
        step(4);
        chk("run_rem8", remaining, 1);
        step(4);
        chk("run_done12", done, 1);
        chk("run_tick12", tick, 1);
        chk("run_busy12", busy, 0);
        chk("run_rem12", remaining, 0);
        step(1);
        chk("run_done13", done, 0);

        // Zero load in IDLE
        load = 1'b1; load_val = 4'd0;
        step(1);
        load = 1'b0;
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        step(1);
        chk("zero_done_clr", done, 0);

        // Reload on a wrap edge with remaining=2
        load = 1'b1; load_val = 4'd3;
        step(1);
        load = 1'b0;
        step(4);
        chk("rld_rem_pre", remaining, 2);
        step(3);
        load = 1'b1; load_val = 4'd5;
        step(1);
        load = 1'b0;
        chk("rld_rem", remaining, 5);
        chk("rld_done", done, 0);
        chk("rld_busy", busy, 1);
        step(19);
        chk("rld_rem19", remaining, 1);
        chk("rld_done19", done, 0);
        step(1);
        chk("rld_done20", done, 1);
        chk("rld_busy20", busy, 0);

        // Freeze with remaining=2, pre_cnt=2
        load = 1'b1; load_val = 4'd3;
        step(1);
        load = 1'b0;
        step(4);
        chk("frz_rem_pre", remaining, 2);
        step(2);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("frz_tick", tick, 0);
        end
        chk("frz_rem", remaining, 2);
        en = 1'b1;
        step(1);
        chk("frz_res_rem1", remaining, 2);
        chk("frz_res_tick1", tick, 0);
        step(1);
        chk("frz_res_rem2", remaining, 1);
        chk("frz_res_tick2", tick, 1);
        step(4);
        chk("frz_done", done, 1);

        // Reset mid-run, with a simultaneous load
        load = 1'b1; load_val = 4'd4;
        step(1);
        load = 1'b0;
        chk("mrst_rem_pre", remaining, 4);
        chk("mrst_busy_pre", busy, 1);
        step(1);
        rst = 1'b1; load = 1'b1; load_val = 4'd7;
        step(1);
        chk("mrst_busy", busy, 0);
        chk("mrst_rem", remaining, 0);
        chk("mrst_tick", tick, 0);
        chk("mrst_done", done, 0);
        rst = 1'b0; load = 1'b0;
        step(4);
        chk("mrst_tick4", tick, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/ck_tick_timer.md
Name: ck_tick_timer

Overview:
- Timebase stage directly downstream of the clock/reset generator. It consumes clk and rst and produces the timing services for the traffic-light (semafor) controller.
- A prescaler divides clk into a one-cycle tick every CK_DIV enabled cycles.
- A loadable down-counter counts ticks and signals expiry with busy/done, so the light FSM can time each phase.

Parameters:
- CK_DIV, 'd4: clk cycles per tick; legal range >= 2.
- TIME_W, 'd6: width of the phase-duration counter, in ticks.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous reset, active-high.
- en  input  1  global count enable; low freezes the prescaler and timer.
- load  input  1  one-cycle request to start or restart the timer.
- load_val  input  TIME_W  duration in ticks, sampled when load=1.
- tick  output  1  registered one-cycle pulse, once per prescaler period.
- busy  output  1  timer running.
- done  output  1  registered one-cycle pulse when the timer expires.
- remaining  output  TIME_W  ticks left; 0 when idle.

Behaviour:
- Clock and reset:
  - One clock, clk. Reset rst is synchronous and active-high: sampled only on posedge clk.
  - rst=1 at an edge forces pre_cnt=0, state=IDLE, tick=0, busy=0, done=0, remaining=0.
  - Reset has priority over every other input, including mid-run and mid-load.
- Prescaler:
  - pre_cnt runs 0..CK_DIV-1 and advances only when en=1.
  - wrap = en && pre_cnt==CK_DIV-1. On wrap, pre_cnt returns to 0.
  - tick is registered: tick<=wrap. It is high for exactly one cycle.
  - After reset release with en held high, the first tick is high following the CK_DIV-th edge.
- Timer FSM, states IDLE and RUN:
  - IDLE, load=1, load_val>0: go to RUN, remaining<=load_val, pre_cnt<=0 (phase-aligned restart).
  - IDLE, load=1, load_val==0: stay IDLE, done<=1 on that edge.
  - RUN, wrap, remaining>1: remaining<=remaining-1.
  - RUN, wrap, remaining==1: remaining<=0, done<=1, go to IDLE. done coincides with that tick.
  - RUN, load=1: reload with load_val and clear pre_cnt. load beats a simultaneous wrap, and the expiry on that edge is suppressed. load_val==0 in RUN goes to IDLE with done<=1.
- Outputs:
  - busy = (state==RUN), registered.
  - done defaults to 0 on every edge it is not set.
- Enable:
  - en=0: pre_cnt and remaining hold, and no tick or done is produced.
  - load is still accepted while en=0.
- Arithmetic: all counters are unsigned. No underflow is possible because the counter decrements only while remaining>=1.

Optional Feature:
- Macro CK_TIMER_AUTORELOAD_EN.
- Defined:
  - Adds input port auto_rld (1 bit).
  - The last accepted nonzero load_val is kept in register rld_val.
  - On expiry with auto_rld=1: done<=1 still pulses, but the FSM stays in RUN and remaining<=rld_val. busy does not drop.
- Undefined: port and register are absent, and the timer is strictly one-shot.

Decomposition:
- Package semafor_pkg holds:
  - State encodings ST_IDLE/ST_RUN as localparams.
  - Default CK_DIV and TIME_W values.
  - The phase durations used by the light FSM, e.g. T_RED, T_YELLOW, T_GREEN.
- Sub-module ck_prescaler (params CK_DIV): ports clk, rst, en, clr, wrap, tick. It encapsulates pre_cnt and tick.
- The ck_tick_timer top instantiates ck_prescaler and holds the FSM and down-counter.

Test Plan (CK_DIV=4, TIME_W=4):
- Reset: rst=1 for 2 edges, then en=1 → all outputs 0 during reset; first tick=1 after the 4th edge after release, then every 4 cycles.
- Basic run: load=1, load_val=3 at edge E → busy=1 and remaining=3 after E; remaining=2 after E+4 and 1 after E+8; done=1 and tick=1 after E+12; busy=0 and remaining=0 after E+12.
- Zero load: load_val=0 in IDLE → done=1 for one cycle after the load edge; busy stays 0.
- Reload mid-run: with remaining=2, load_val=5 on a wrap edge → remaining=5, no decrement, no done; expiry occurs 20 cycles later.
- Freeze: en=0 for 10 cycles while remaining=2 → no tick, remaining holds 2; after en=1, the timer resumes from the frozen pre_cnt.
- Reset mid-run: rst=1 while busy with remaining=4 → busy=0, remaining=0, tick=0, done=0 after that edge.
